// File: rtl/regfile_pkg.sv
// Shared constants and index type for the RV32 register file with busy scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);
  localparam int unsigned REG_ZERO  = 0;

  typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file; master = pipeline side, slave = regfile_sb.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic                 wen;
  logic [AW-1:0]        regW_sel;
  logic [XLEN-1:0]      regW_i;
  logic [NRD*AW-1:0]    rd_sel;
  logic [NRD*XLEN-1:0]  rd_o;
  logic [NRD-1:0]       rd_busy_o;
  logic                 issue_en;
  logic [AW-1:0]        issue_sel;
  logic                 flush;
  logic [NREGS-1:0]     busy_o;

  modport master (
    output wen, regW_sel, regW_i, rd_sel, issue_en, issue_sel, flush,
    input  rd_o, rd_busy_o, busy_o
  );

  modport slave (
    input  wen, regW_sel, regW_i, rd_sel, issue_en, issue_sel, flush,
    output rd_o, rd_busy_o, busy_o
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: flush beats issue, issue beats writeback; entry 0 never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen_i,
  input  logic [AW-1:0]    wsel_i,
  input  logic             issue_en_i,
  input  logic [AW-1:0]    issue_sel_i,
  input  logic             flush_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (r == REG_ZERO) begin
        busy_d[r] = 1'b0;
      end else if (flush_i) begin
        busy_d[r] = 1'b0;
      end else if (issue_en_i && (issue_sel_i == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wen_i && (wsel_i == AW'(r))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with integrated busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  localparam int unsigned   AW       = $clog2(NREGS);
  localparam logic [AW-1:0] IDX_ZERO = AW'(REG_ZERO);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NREGS-1:0]    busy_s;
  logic                wr_hit_s;
  logic [NRD*XLEN-1:0] rd_data_s;
  logic [NRD-1:0]      rd_busy_s;

  assign wr_hit_s = bus.wen && (bus.regW_sel != IDX_ZERO);

  regfile_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wen_i       (bus.wen),
    .wsel_i      (bus.regW_sel),
    .issue_en_i  (bus.issue_en),
    .issue_sel_i (bus.issue_sel),
    .flush_i     (bus.flush),
    .busy_o      (busy_s)
  );

  // Entry 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_hit_s) begin
      regs_q[bus.regW_sel] <= bus.regW_i;
    end
  end

  always_comb begin
    rd_data_s = '0;
    rd_busy_s = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      if (bus.rd_sel[p*AW +: AW] == IDX_ZERO) begin
        rd_data_s[p*XLEN +: XLEN] = '0;
        rd_busy_s[p]              = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      // Forwarded result arrives this cycle, so the hazard is already resolved.
      else if (wr_hit_s && (bus.rd_sel[p*AW +: AW] == bus.regW_sel)) begin
        rd_data_s[p*XLEN +: XLEN] = bus.regW_i;
        rd_busy_s[p]              = 1'b0;
      end
`endif
      else begin
        rd_data_s[p*XLEN +: XLEN] = regs_q[bus.rd_sel[p*AW +: AW]];
        rd_busy_s[p]              = busy_s[bus.rd_sel[p*AW +: AW]];
      end
    end
  end

  assign bus.rd_o      = rd_data_s;
  assign bus.rd_busy_o = rd_busy_s;
  assign bus.busy_o    = busy_s;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (NRD=3) against an array/bit-vector reference model.
module tb_regfile_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 3;

  logic clk;
  logic rst;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mdl_regs [32];
  logic [31:0] mdl_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wen && (bus.regW_sel != 5'd0) && (s == bus.regW_sel)) return bus.regW_i;
`endif
    return mdl_regs[s];
  endfunction

  function automatic logic exp_rdb(input logic [4:0] s);
`ifdef REGFILE_BYPASS_EN
    if (bus.wen && (bus.regW_sel != 5'd0) && (s == bus.regW_sel)) return 1'b0;
`endif
    return mdl_busy[s];
  endfunction

  function automatic logic [95:0] exp_rd_all();
    logic [95:0] v = 96'd0;
    for (int p = 0; p < 3; p++) v[p*32 +: 32] = exp_rd(bus.rd_sel[p*5 +: 5]);
    return v;
  endfunction

  function automatic logic [2:0] exp_rdb_all();
    logic [2:0] v = 3'd0;
    for (int p = 0; p < 3; p++) v[p] = exp_rdb(bus.rd_sel[p*5 +: 5]);
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 32; r++) mdl_regs[r] = 32'd0;
    mdl_busy = 32'd0;
  endtask

  // Apply the edge's events in increasing precedence: writeback, then issue, then flush.
  task automatic model_edge();
    logic [31:0] nb;
    nb = mdl_busy;
    if (bus.wen) nb[bus.regW_sel] = 1'b0;
    if (bus.issue_en) nb[bus.issue_sel] = 1'b1;
    if (bus.flush) nb = 32'd0;
    nb[0] = 1'b0;
    mdl_busy = nb;
    if (bus.wen && (bus.regW_sel != 5'd0)) mdl_regs[bus.regW_sel] = bus.regW_i;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    bus.wen       = 1'b0;
    bus.regW_sel  = 5'd0;
    bus.regW_i    = 32'd0;
    bus.issue_en  = 1'b0;
    bus.issue_sel = 5'd0;
    bus.flush     = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] idx;
    drive_idle();
    bus.rd_sel = 15'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 32; i++) begin
      idx = 5'(i);
      bus.rd_sel = {idx, idx, idx};
      #1;
      tests_run++;
      if (bus.rd_o !== 96'd0 || bus.rd_busy_o !== 3'd0) begin
        tests_failed++;
        $display("FAIL reset_read idx=%0d got rd=%h busy=%b exp rd=0 busy=0", i, bus.rd_o, bus.rd_busy_o);
      end
    end
    tests_run++;
    if (bus.busy_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_busy got=%h exp=0", bus.busy_o);
    end
  endtask

  task automatic test_write_readback();
    logic [4:0] idx;
    for (int i = 1; i < 32; i++) begin
      bus.wen = 1'b1;
      bus.regW_sel = 5'(i);
      bus.regW_i = $urandom;
      tick();
    end
    bus.regW_sel = 5'd0;
    bus.regW_i = 32'hDEADBEEF;
    tick();
    drive_idle();
    for (int i = 0; i < 32; i++) begin
      idx = 5'(i);
      bus.rd_sel = {idx, idx, idx};
      #1;
      tests_run++;
      if (bus.rd_o !== exp_rd_all()) begin
        tests_failed++;
        $display("FAIL readback idx=%0d got=%h exp=%h", i, bus.rd_o, exp_rd_all());
      end
    end
    bus.rd_sel = 15'd0;
    #1;
    tests_run++;
    if (bus.rd_o !== 96'd0) begin
      tests_failed++;
      $display("FAIL reg0_after_write got=%h exp=0", bus.rd_o);
    end
  endtask

  task automatic test_scoreboard();
    bus.issue_en = 1'b1;
    bus.issue_sel = 5'd5;
    tick();
    bus.issue_en = 1'b0;
    bus.rd_sel = {5'd5, 5'd5, 5'd5};
    #1;
    tests_run++;
    if (bus.busy_o[5] !== 1'b1 || bus.rd_busy_o !== 3'b111) begin
      tests_failed++;
      $display("FAIL sb_issue got busy5=%b rd_busy=%b exp 1/111", bus.busy_o[5], bus.rd_busy_o);
    end
    repeat (3) tick();
    tests_run++;
    if (bus.busy_o[5] !== 1'b1) begin
      tests_failed++;
      $display("FAIL sb_hold got=%b exp=1", bus.busy_o[5]);
    end
    bus.wen = 1'b1;
    bus.regW_sel = 5'd5;
    bus.regW_i = 32'h1234;
    tick();
    drive_idle();
    #1;
    tests_run++;
    if (bus.busy_o[5] !== 1'b0 || bus.rd_o !== {3{32'h1234}} || bus.busy_o !== mdl_busy) begin
      tests_failed++;
      $display("FAIL sb_writeback got busy=%h rd=%h exp busy=%h rd=%h", bus.busy_o, bus.rd_o, mdl_busy, {3{32'h1234}});
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    d = $urandom;
    bus.issue_en = 1'b1;
    bus.issue_sel = 5'd7;
    bus.wen = 1'b1;
    bus.regW_sel = 5'd7;
    bus.regW_i = d;
    tick();
    drive_idle();
    bus.rd_sel = {5'd7, 5'd7, 5'd7};
    #1;
    tests_run++;
    if (bus.busy_o[7] !== 1'b1 || bus.rd_o[31:0] !== d) begin
      tests_failed++;
      $display("FAIL issue_vs_wb got busy7=%b rd=%h exp 1 %h", bus.busy_o[7], bus.rd_o[31:0], d);
    end
    bus.issue_en = 1'b1;
    bus.issue_sel = 5'd3; tick();
    bus.issue_sel = 5'd4; tick();
    bus.issue_sel = 5'd9; tick();
    tests_run++;
    if (bus.busy_o !== 32'h0000_0298) begin
      tests_failed++;
      $display("FAIL multi_issue got=%h exp=00000298", bus.busy_o);
    end
    d = $urandom;
    bus.issue_sel = 5'd10;
    bus.flush = 1'b1;
    bus.wen = 1'b1;
    bus.regW_sel = 5'd3;
    bus.regW_i = d;
    tick();
    drive_idle();
    bus.rd_sel = {5'd0, 5'd3, 5'd3};
    #1;
    tests_run++;
    if (bus.busy_o !== 32'd0 || bus.rd_o[63:0] !== {d, d}) begin
      tests_failed++;
      $display("FAIL flush got busy=%h rd=%h exp busy=0 rd=%h", bus.busy_o, bus.rd_o[63:0], {d, d});
    end
  endtask

  task automatic test_bypass();
    logic [31:0] old;
    bus.issue_en = 1'b1;
    bus.issue_sel = 5'd12;
    tick();
    drive_idle();
    old = mdl_regs[12];
    bus.wen = 1'b1;
    bus.regW_sel = 5'd12;
    bus.regW_i = 32'hA5A5A5A5;
    bus.rd_sel = {5'd0, 5'd12, 5'd0};
    #1;
    tests_run++;
`ifdef REGFILE_BYPASS_EN
    if (bus.rd_o[63:32] !== 32'hA5A5A5A5 || bus.rd_busy_o[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle got rd=%h busy=%b exp a5a5a5a5 0", bus.rd_o[63:32], bus.rd_busy_o[1]);
    end
`else
    if (bus.rd_o[63:32] !== old || bus.rd_busy_o[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL no_bypass_same_cycle got rd=%h busy=%b exp %h 1", bus.rd_o[63:32], bus.rd_busy_o[1], old);
    end
`endif
    tick();
    drive_idle();
    #1;
    tests_run++;
    if (bus.rd_o[63:32] !== 32'hA5A5A5A5 || bus.rd_busy_o[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_after_edge got rd=%h busy=%b exp a5a5a5a5 0", bus.rd_o[63:32], bus.rd_busy_o[1]);
    end
  endtask

  task automatic test_random();
    logic [14:0] sel;
    for (int c = 0; c < 400; c++) begin
      bus.wen       = ($urandom_range(1, 0) == 1);
      bus.regW_sel  = 5'($urandom_range(31, 0));
      bus.regW_i    = $urandom;
      bus.issue_en  = ($urandom_range(9, 0) < 3);
      bus.issue_sel = 5'($urandom_range(31, 0));
      bus.flush     = ($urandom_range(19, 0) == 0);
      sel = 15'($urandom);
      if ($urandom_range(3, 0) == 0) sel[5:9-4] = bus.regW_sel;
      bus.rd_sel = sel;
      #1;
      tests_run++;
      if (bus.rd_o !== exp_rd_all() || bus.rd_busy_o !== exp_rdb_all() || bus.busy_o !== mdl_busy) begin
        tests_failed++;
        $display("FAIL random c=%0d got rd=%h rb=%b busy=%h exp rd=%h rb=%b busy=%h",
                 c, bus.rd_o, bus.rd_busy_o, bus.busy_o, exp_rd_all(), exp_rdb_all(), mdl_busy);
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    bus.issue_en = 1'b1;
    bus.issue_sel = 5'd20;
    bus.wen = 1'b1;
    bus.regW_sel = 5'd21;
    bus.regW_i = $urandom | 32'h1;
    tick();
    drive_idle();
    bus.rd_sel = {5'd21, 5'd20, 5'd21};
    #1;
    tests_run++;
    if (bus.rd_o !== exp_rd_all() || bus.busy_o !== mdl_busy || bus.busy_o[20] !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_async_reset got rd=%h busy=%h exp rd=%h busy=%h", bus.rd_o, bus.busy_o, exp_rd_all(), mdl_busy);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.rd_o !== 96'd0 || bus.rd_busy_o !== 3'd0 || bus.busy_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL async_reset got rd=%h rb=%b busy=%h exp 0", bus.rd_o, bus.rd_busy_o, bus.busy_o);
    end
    #1;
    rst = 1'b0;
    clear_model();
    tick();
    tests_run++;
    if (bus.rd_o !== 96'd0 || bus.busy_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL post_async_reset got rd=%h busy=%h exp 0", bus.rd_o, bus.busy_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    bus.rd_sel = 15'd0;
    test_reset();
    test_write_readback();
    test_scoreboard();
    test_simultaneous();
    test_bypass();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port register file for the RV32 core, integrating a per-register busy scoreboard.
- Successor to the fixed 32x32, two-read-port regfile.
- Sits between decode (reads, issue) and writeback (write port).
- Decode uses the busy flags to detect RAW hazards on long-latency results (loads, multi-cycle ops) and stall until writeback.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NRD, 2, number of independent read ports, 1..4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wen  input  1  writeback write enable.
- regW_sel  input  AW  writeback destination index, where AW = $clog2(NREGS).
- regW_i  input  XLEN  writeback data.
- rd_sel  input  NRD x AW  read index per port (packed, port 0 in LSBs).
- rd_o  output  NRD x XLEN  read data per port.
- rd_busy_o  output  NRD  busy flag of the register selected on each port.
- issue_en  input  1  decode issues an instruction with a pending long-latency destination.
- issue_sel  input  AW  destination index of that instruction.
- flush  input  1  pipeline flush; discards all pending destinations.
- busy_o  output  NREGS  full scoreboard vector, for debug and the hazard unit.

Behaviour:
- Reset (asynchronous, rst=1):
  - all registers cleared to 0;
  - all busy bits cleared;
  - rd_o reflects 0 for every selection;
  - rd_busy_o=0, busy_o=0.
- Register 0 is hardwired:
  - reads always return 0;
  - writes to index 0 are ignored;
  - busy[0] is never set; issue_sel=0 is ignored.
- Write: on rising edge with wen=1 and regW_sel!=0, regs[regW_sel] <= regW_i. One-cycle write latency.
- Read: combinational, zero latency. rd_o[p] = regs[rd_sel[p]], subject to the optional bypass.
  - Any number of ports may select the same index; all return identical data.
- Scoreboard, per register r != 0, evaluated each rising edge in this priority order:
  1. flush=1: busy[r] <= 0 for all r, overriding issue and writeback in the same cycle.
  2. issue_en=1 and issue_sel==r: busy[r] <= 1. Issue wins over a same-cycle writeback to r, because the newer instruction still owes a result.
  3. wen=1 and regW_sel==r: busy[r] <= 0.
  4. Otherwise busy[r] holds.
- Writeback to a non-busy register is legal: data is written, busy stays 0.
- Issue to an already-busy register is legal: busy stays 1 (single bit, no counting).
- flush does not affect register contents. A wen in the same cycle as flush still writes.
- rd_busy_o[p]:
  - without bypass: busy[rd_sel[p]];
  - with bypass: see Optional Feature.
- Reset asserted mid-operation clears state immediately, independent of clk. First update after rst deasserts is on the next rising edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - write-to-read forwarding: if wen=1, regW_sel!=0 and rd_sel[p]==regW_sel, then rd_o[p]=regW_i in the same cycle;
  - rd_busy_o[p] is also forced to 0 for that port, because the result arrives this cycle.
- Undefined:
  - rd_o[p] returns the old stored value until the edge after the write;
  - rd_busy_o[p]=busy[rd_sel[p]] regardless of wen.
- Both builds must pass the same bench. Bypass-specific checks are guarded by the same macro.

Decomposition:
- Package regfile_pkg holds:
  - default constants XLEN_DEF=32, NREGS_DEF=32;
  - the reg-index typedef reg_idx_t (logic [AW-1:0] for the default depth);
  - REG_ZERO=0.
- One sub-module: regfile_scoreboard. It holds the busy vector and the flush/issue/writeback priority logic, and exposes busy_o.
- Data array, read muxing and bypass remain in regfile_sb.

Test Plan:
- Reset:
  - Stimulus: assert rst for 3 cycles, deassert; sweep rd_sel on all ports over 0..NREGS-1.
  - Required: rd_o=0 and rd_busy_o=0 at every index; busy_o=0.
- Write/readback (NRD=3 build):
  - Stimulus: write $random to regs 1..31 with wen=1, then wen=0; read index i on all three ports.
  - Required: every port returns the written value; index 0 returns 0 after writing 32'hDEADBEEF to it.
- Scoreboard:
  - Stimulus: issue_sel=5 → busy_o[5]=1, rd_busy_o=1 when rd_sel=5. After 3 idle cycles, wen=1, regW_sel=5, regW_i=32'h1234.
  - Required: busy_o[5]=0 after the edge; rd_o=32'h1234.
- Simultaneous events:
  - Stimulus A: issue_sel=7 and wen with regW_sel=7 in the same cycle.
  - Required A: busy_o[7]=1 and regs[7] is written.
  - Stimulus B: issue regs 3,4,9, then flush together with issue_sel=10.
  - Required B: busy_o=0.
- Bypass (REGFILE_BYPASS_EN defined):
  - Stimulus: with busy[12]=1, drive wen=1, regW_sel=12, regW_i=32'hA5A5A5A5, rd_sel[1]=12.
  - Required: rd_o[1]=32'hA5A5A5A5 and rd_busy_o[1]=0 in the same cycle.
  - Undefined build: old value and rd_busy_o[1]=1 until the edge.
- Async reset mid-operation:
  - Stimulus: pulse rst between clock edges while regs are populated and busy bits are set.
  - Required: rd_o and busy_o drop to 0 before the next rising edge.
